// File: rtl/ram_sized_mc.sv
// rtl/ram_sized_mc.sv - multi-cycle big-endian byte RAM with byte/half/word/doubleword accesses
// Alignment checking is built in when RAM_ALIGN_CHECK_EN is defined.
module ram_sized_mc #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        MOV,
    input  logic        ReadWrite,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [31:0] DataInHi,
    output logic [31:0] DataOut,
    output logic [31:0] DataOutHi,
    output logic        MOC,
    output logic        Fault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_LAST = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ACCESS2,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          moc_q, moc_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   douthi_q, douthi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          rw_q, rw_d;
    logic          sext_q, sext_d;
    logic [31:0]   din_q, din_d;
    logic [31:0]   dinhi_q, dinhi_d;

    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] base_addr, a0, a1, a2, a3;
    logic [31:0]   rd_word, wr_word;
    logic [3:0]    we;
    logic [7:0]    wb0, wb1, wb2, wb3;
    logic          do_access, dword, misalign;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^Address[31:AW];

    // Second half of a doubleword addresses A+4; every byte index wraps modulo DEPTH.
    assign base_addr = (state_q == S_ACCESS2) ? addr_q + AW'(4) : addr_q;
    assign a0        = base_addr;
    assign a1        = base_addr + AW'(1);
    assign a2        = base_addr + AW'(2);
    assign a3        = base_addr + AW'(3);
    assign rd_word   = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
    assign dword     = (size_q == 2'b11);
    assign wr_word   = (dword && state_q == S_ACCESS) ? dinhi_q : din_q;

`ifdef RAM_ALIGN_CHECK_EN
    logic fault_q;

    assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));

    // Fault rides along with MOC, so it rises and clears on the same edges.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= moc_d && misalign;
        end
    end

    assign Fault = fault_q;
`else
    assign misalign = 1'b0;
    assign Fault    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        moc_d     = moc_q;
        addr_d    = addr_q;
        size_d    = size_q;
        rw_d      = rw_q;
        sext_d    = sext_q;
        din_d     = din_q;
        dinhi_d   = dinhi_q;
        do_access = 1'b0;

        case (state_q)
            S_IDLE: begin
                moc_d = 1'b0;
                cnt_d = 4'd0;
                if (MOV && Enable) begin
                    addr_d  = Address[AW-1:0];
                    size_d  = Size;
                    rw_d    = ReadWrite;
                    sext_d  = SignExt;
                    din_d   = DataIn;
                    dinhi_d = DataInHi;
                    state_d = (LATENCY == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == LAT_LAST) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                do_access = 1'b1;
                if (dword) begin
                    state_d = S_ACCESS2;
                end else begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                end
            end
            S_ACCESS2: begin
                do_access = 1'b1;
                state_d   = S_DONE;
                moc_d     = 1'b1;
            end
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                moc_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        dout_d   = dout_q;
        douthi_d = douthi_q;
        we       = 4'b0000;
        wb0      = wr_word[31:24];
        wb1      = wr_word[23:16];
        wb2      = wr_word[15:8];
        wb3      = wr_word[7:0];

        if (do_access && !misalign) begin
            if (rw_q) begin
                if (dword) begin
                    if (state_q == S_ACCESS) begin
                        douthi_d = rd_word;
                    end else begin
                        dout_d = rd_word;
                    end
                end else begin
                    case (size_q)
                        2'b00:   dout_d = {{24{sext_q & rd_word[31]}}, rd_word[31:24]};
                        2'b01:   dout_d = {{16{sext_q & rd_word[31]}}, rd_word[31:16]};
                        default: dout_d = rd_word;
                    endcase
                end
            end else begin
                case (size_q)
                    2'b00: begin
                        we  = 4'b0001;
                        wb0 = wr_word[7:0];
                    end
                    2'b01: begin
                        we  = 4'b0011;
                        wb0 = wr_word[15:8];
                        wb1 = wr_word[7:0];
                    end
                    default: we = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            moc_q    <= 1'b0;
            dout_q   <= 32'd0;
            douthi_q <= 32'd0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            rw_q     <= 1'b0;
            sext_q   <= 1'b0;
            din_q    <= 32'd0;
            dinhi_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            moc_q    <= moc_d;
            dout_q   <= dout_d;
            douthi_q <= douthi_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            rw_q     <= rw_d;
            sext_q   <= sext_d;
            din_q    <= din_d;
            dinhi_q  <= dinhi_d;
        end
    end

    // Memory has no reset; a reset edge only suppresses the write on that edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (we[0]) mem_q[a0] <= wb0;
            if (we[1]) mem_q[a1] <= wb1;
            if (we[2]) mem_q[a2] <= wb2;
            if (we[3]) mem_q[a3] <= wb3;
        end
    end

    assign DataOut   = dout_q;
    assign DataOutHi = douthi_q;
    assign MOC       = moc_q;
endmodule

// File: tb/tb_ram_sized_mc.sv
// tb/tb_ram_sized_mc.sv - directed vector bench for ram_sized_mc (DEPTH=1024, LATENCY=3)
module tb_ram_sized_mc;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b0;
    logic        MOV = 1'b0;
    logic        ReadWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        SignExt = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataInHi = 32'd0;
    logic [31:0] DataOut;
    logic [31:0] DataOutHi;
    logic        MOC;
    logic        Fault;

    int total = 0;
    int bad   = 0;

    ram_sized_mc #(.DEPTH(1024), .LATENCY(3)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .MOV(MOV), .ReadWrite(ReadWrite),
        .Size(Size), .SignExt(SignExt), .Address(Address), .DataIn(DataIn),
        .DataInHi(DataInHi), .DataOut(DataOut), .DataOutHi(DataOutHi), .MOC(MOC), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        se;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] dh;
        logic [31:0] eo;
        logic [31:0] eoh;
        int          elat;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Inputs are scrambled and Enable dropped right after capture: the access must use latched values.
    task automatic do_op(input logic rw, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] dh,
                         output logic [31:0] o, output logic [31:0] oh, output logic f,
                         output int lat);
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = rw; Size = sz; SignExt = se;
        Address = a; DataIn = d; DataInHi = dh;
        @(posedge Clk); #1;
        Address = ~a; DataIn = ~d; DataInHi = ~dh; Size = ~sz; ReadWrite = ~rw;
        SignExt = ~se; Enable = 1'b0;
        lat = 0;
        while (MOC !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        o = DataOut; oh = DataOutHi; f = Fault;
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check("moc_fall", {31'd0, MOC}, 32'd0);
        check("fault_fall", {31'd0, Fault}, 32'd0);
    endtask

    initial begin
        logic [31:0] o, oh, hold;
        logic        f;
        int          lat;
        logic        saw;

        tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 32'h00000000, 32'h00000000, 4};
        tbl[1]  = '{1'b1, 2'b00, 1'b1, 32'h010, 32'h0, 32'h0, 32'hFFFFFFDE, 32'h00000000, 4};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h010, 32'h0, 32'h0, 32'h000000DE, 32'h00000000, 4};
        tbl[3]  = '{1'b1, 2'b01, 1'b1, 32'h012, 32'h0, 32'h0, 32'hFFFFBEEF, 32'h00000000, 4};
        tbl[4]  = '{1'b1, 2'b01, 1'b0, 32'h012, 32'h0, 32'h0, 32'h0000BEEF, 32'h00000000, 4};
        tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 32'h0, 32'hDEADBEEF, 32'h00000000, 4};
        tbl[6]  = '{1'b0, 2'b00, 1'b0, 32'h011, 32'h12345677, 32'h0, 32'hDEADBEEF, 32'h00000000, 4};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 32'h0, 32'hDE77BEEF, 32'h00000000, 4};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h012, 32'hAAAA1234, 32'h0, 32'hDE77BEEF, 32'h00000000, 4};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 32'h0, 32'hDE771234, 32'h00000000, 4};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h3FC, 32'h55667788, 32'h11223344, 32'hDE771234, 32'h00000000, 5};
        tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h3FC, 32'h0, 32'h0, 32'h55667788, 32'h11223344, 5};
        tbl[12] = '{1'b1, 2'b00, 1'b0, 32'h000, 32'h0, 32'h0, 32'h00000055, 32'h11223344, 4};
        tbl[13] = '{1'b1, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h0, 32'h00000044, 32'h11223344, 4};
        tbl[14] = '{1'b1, 2'b10, 1'b0, 32'h410, 32'h0, 32'h0, 32'hDE771234, 32'h11223344, 4};
        tbl[15] = '{1'b1, 2'b01, 1'b1, 32'h3FE, 32'h0, 32'h0, 32'h00003344, 32'h11223344, 4};
        tbl[16] = '{1'b1, 2'b01, 1'b1, 32'h010, 32'h0, 32'h0, 32'hFFFFDE77, 32'h11223344, 4};

        repeat (2) @(posedge Clk);
        #1;
        check("rst_moc", {31'd0, MOC}, 32'd0);
        check("rst_fault", {31'd0, Fault}, 32'd0);
        check("rst_dout", DataOut, 32'd0);
        check("rst_douthi", DataOutHi, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].rw, tbl[i].sz, tbl[i].se, tbl[i].a, tbl[i].d, tbl[i].dh, o, oh, f, lat);
            check($sformatf("v%0d_dout", i), o, tbl[i].eo);
            check($sformatf("v%0d_douthi", i), oh, tbl[i].eoh);
            check($sformatf("v%0d_lat", i), lat, tbl[i].elat);
            check($sformatf("v%0d_fault", i), {31'd0, f}, 32'd0);
        end

        // MOC holds with stable data while MOV stays high, falls on the edge MOV=0 is sampled.
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = 1'b1; Size = 2'b10; SignExt = 1'b0; Address = 32'h010;
        @(posedge Clk); #1;
        lat = 0;
        while (MOC !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("hold_lat", lat, 4);
        hold = DataOut;
        check("hold_data", hold, 32'hDE771234);
        repeat (3) begin
            @(posedge Clk); #1;
            check("hold_moc", {31'd0, MOC}, 32'd1);
            check("hold_stable", DataOut, 32'hDE771234);
        end
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check("hold_fall", {31'd0, MOC}, 32'd0);

        // Abort during WAIT: write never lands, MOC never rises.
        do_op(1'b0, 2'b10, 1'b0, 32'h020, 32'h01020304, 32'h0, o, oh, f, lat);
        do_op(1'b0, 2'b10, 1'b0, 32'h024, 32'h05060708, 32'h0, o, oh, f, lat);
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = 1'b0; Size = 2'b10; Address = 32'h020; DataIn = 32'hCAFEBABE;
        @(posedge Clk);
        @(negedge Clk);
        MOV = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(posedge Clk); #1;
            if (MOC === 1'b1) saw = 1'b1;
        end
        check("abort_moc", {31'd0, saw}, 32'd0);
        do_op(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0, o, oh, f, lat);
        check("abort_mem", o, 32'h01020304);

        // Reset in WAIT clears outputs but not memory.
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = 1'b1; Size = 2'b11; Address = 32'h3FC;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rstw_moc", {31'd0, MOC}, 32'd0);
        check("rstw_dout", DataOut, 32'd0);
        check("rstw_douthi", DataOutHi, 32'd0);
        @(negedge Clk);
        Reset = 1'b1; MOV = 1'b0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (MOC === 1'b1) saw = 1'b1;
        end
        check("rstw_nomoc", {31'd0, saw}, 32'd0);
        do_op(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0, o, oh, f, lat);
        check("rstw_mem", o, 32'h01020304);

        // MOV dropped in ACCESS: write completes with a one-cycle MOC pulse.
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = 1'b0; Size = 2'b10; Address = 32'h030; DataIn = 32'h0BADF00D;
        @(posedge Clk);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check("acc_drop_moc", {31'd0, MOC}, 32'd1);
        @(posedge Clk); #1;
        check("acc_drop_fall", {31'd0, MOC}, 32'd0);
        do_op(1'b1, 2'b10, 1'b0, 32'h030, 32'h0, 32'h0, o, oh, f, lat);
        check("acc_drop_mem", o, 32'h0BADF00D);

        // Enable low blocks acceptance.
        @(negedge Clk);
        Enable = 1'b0; MOV = 1'b1; ReadWrite = 1'b0; Size = 2'b10; Address = 32'h030; DataIn = 32'h11111111;
        saw = 1'b0;
        repeat (8) begin
            @(posedge Clk); #1;
            if (MOC === 1'b1) saw = 1'b1;
        end
        check("en_block", {31'd0, saw}, 32'd0);
        @(negedge Clk);
        MOV = 1'b0;
        do_op(1'b1, 2'b10, 1'b0, 32'h030, 32'h0, 32'h0, o, oh, f, lat);
        check("en_block_mem", o, 32'h0BADF00D);

        // Misaligned word write at 0x22.
        @(negedge Clk);
        Enable = 1'b1; MOV = 1'b1; ReadWrite = 1'b0; Size = 2'b10; Address = 32'h022; DataIn = 32'hA1B2C3D4;
        @(posedge Clk); #1;
        lat = 0;
        while (MOC !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("mis_lat", lat, 4);
`ifdef RAM_ALIGN_CHECK_EN
        check("mis_fault", {31'd0, Fault}, 32'd1);
`else
        check("mis_fault", {31'd0, Fault}, 32'd0);
`endif
        check("mis_dout", DataOut, 32'h0BADF00D);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check("mis_moc_fall", {31'd0, MOC}, 32'd0);
        check("mis_fault_fall", {31'd0, Fault}, 32'd0);
        do_op(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0, o, oh, f, lat);
`ifdef RAM_ALIGN_CHECK_EN
        check("mis_mem_lo", o, 32'h01020304);
`else
        check("mis_mem_lo", o, 32'h0102A1B2);
`endif
        do_op(1'b1, 2'b10, 1'b0, 32'h024, 32'h0, 32'h0, o, oh, f, lat);
`ifdef RAM_ALIGN_CHECK_EN
        check("mis_mem_hi", o, 32'h05060708);
`else
        check("mis_mem_hi", o, 32'hC3D40708);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
